// File: rtl/ser_pkg.sv
// Shared definitions for the register readout serializer: FSM state codes and a width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ser_pkg;

    // Two-bit state codes kept as plain constants so older tooling can share them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Counter width that never collapses to zero bits (a count of 1 still needs one bit).
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/reg_readout_serializer_if.sv
// Bundle of the parallel-input handshake and the serial readback outputs.
// Latency: n/a (wires only).
// Backpressure: in_ready is driven by the slave; the master holds in_valid/in_data until accepted.
// Signals: in_valid/in_data (master->slave), in_ready (slave->master),
//          ser_out, ser_frame, ser_bit_strobe, busy, done (slave->master).
interface reg_readout_serializer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_frame;
    logic             ser_bit_strobe;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_frame, ser_bit_strobe, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_frame, ser_bit_strobe, busy, done
    );
endinterface

// File: rtl/reg_readout_serializer_divider.sv
// Bit-period divider: counts clocks within one serial bit and flags the last clock of the period.
// Latency: tick_o is combinational from the count; strobe_o is registered and aligned with that count.
// Backpressure: none; counts only while enabled and restarts from zero whenever disabled.
// Ports: en_i (current state is SHIFT), en_next_i (next state is SHIFT),
//        tick_o (last clock of the current bit period), strobe_o (registered copy for the pin).
module bit_rate_divider
    import ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic en_next_i,
    output logic tick_o,
    output logic strobe_o
);
    localparam int            DW   = clog2_min1(CLKS_PER_BIT);
    localparam logic [DW-1:0] LAST = DW'(CLKS_PER_BIT - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          strobe_q, strobe_d;

    assign tick_o   = en_i && (div_cnt_q == LAST);
    assign strobe_o = strobe_q;

    always_comb begin
        div_cnt_d = '0;
        if (en_i && !tick_o) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
        // Strobe is registered from the next count so it lines up with the held bit.
        strobe_d = en_next_i && (div_cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            strobe_q  <= strobe_d;
        end
    end
endmodule

// File: rtl/reg_readout_serializer.sv
// Parallel-to-serial readback of a register word onto a debug pin, one bit per CLKS_PER_BIT clocks.
// Latency: first bit the cycle after accept; done pulses WIDTH*CLKS_PER_BIT+1 cycles after accept.
// Backpressure: in_ready is high only in IDLE; words offered during a frame wait for the next IDLE cycle.
// Ports: clk, reset_n (synchronous, active-low), bus (slave side of reg_readout_serializer_if).
module reg_readout_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    reg_readout_serializer_if.slave  bus
);
    localparam int            BW       = clog2_min1(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam int            OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in_ready;
    logic             accept;
    logic             tick;
    logic             strobe;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = bus.in_valid && in_ready;

    bit_rate_divider #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (state_q == ST_SHIFT),
        .en_next_i (state_d == ST_SHIFT),
        .tick_o    (tick),
        .strobe_o  (strobe)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = bus.in_data;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    // Hold the count at the final bit instead of wrapping.
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pin values are registered from next-state so every output is a flop.
        frame_d   = (state_d == ST_SHIFT);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        ser_out_d = frame_d && shift_d[OUT_IDX];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ser_out_q <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ser_out_q <= ser_out_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.ser_out        = ser_out_q;
    assign bus.ser_frame      = frame_q;
    assign bus.ser_bit_strobe = strobe;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule
